fir_chan_ingest: RTL and testbench

- Parametrised multichannel input front-end for the time-sliced FIR engine.
- Accepts per-channel (data, changed-toggle) pairs from unrelated sample-clock domains and synchronises each toggle into iClk.
- Captures each new sample into a small per-channel FIFO and serves samples to the engine's update cycle by channel select.
- Unlike the current fixed 5-channel, single-register input path, it adds generic channel count and width, buffering, and sticky overflow/underflow status.

---
 rtl/fir_ingest_pkg.sv | 25 ++
 rtl/fir_toggle_sync.sv | 30 +++
 rtl/fir_chan_ingest.sv | 137 +++++++++++++
 tb/tb_fir_chan_ingest.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fir_ingest_pkg.sv
// Shared defaults and helpers for the FIR engine input front-end.
// Channel slicing works on a bus padded to the largest supported configuration.
package fir_ingest_pkg;

  localparam int DEF_NUM_CH      = 5;
  localparam int DEF_DATA_W      = 18;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOG2DEPTH   = 2;
  localparam int DEF_CH_SEL_W    = 4;

  localparam int NO_CHANNEL = 0;
  localparam int MAX_CH     = 15;
  localparam int MAX_DATA_W = 32;
  localparam int MAX_BUS_W  = MAX_CH * MAX_DATA_W;

  // Returns channel ch of a packed bus of w-bit lanes; caller truncates to its width.
  function automatic logic [MAX_DATA_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned ch,
                                                     input int unsigned w);
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (ch * w);
    return MAX_DATA_W'(shifted);
  endfunction

endpackage

// File: rtl/fir_toggle_sync.sv
// One channel's toggle synchroniser with edge detect; events are masked until armed.
// The previous-value register always follows the last stage so arming absorbs idle levels.
module fir_toggle_sync
  import fir_ingest_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iToggle,
  input  logic iArmed,
  output logic oEvent
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iToggle};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign oEvent = iArmed & (r_sync[SYNC_STAGES-1] ^ r_prev);

endmodule

// File: rtl/fir_chan_ingest.sv
// Multichannel input front-end: toggle-synchronised capture into per-channel FIFOs,
// read by 1-based channel select, with sticky overflow/underflow status.
module fir_chan_ingest
  import fir_ingest_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOG2DEPTH   = DEF_LOG2DEPTH,
  parameter int CH_SEL_W    = DEF_CH_SEL_W
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [NUM_CH-1:0]          iDataChanged,
  input  logic [NUM_CH*DATA_W-1:0]   iData,
  input  logic [CH_SEL_W-1:0]        iRdCh,
  input  logic                       iRdEn,
  output logic [DATA_W-1:0]          oRdData,
  output logic                       oRdValid,
  output logic [NUM_CH-1:0]          oPending,
  output logic [NUM_CH-1:0]          oOverflow,
  output logic [NUM_CH-1:0]          oUnderflow,
  input  logic                       iClrStatus
);

  localparam int PW    = LOG2DEPTH + 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  logic [ARM_W-1:0]     r_arm_cnt;
  logic                 w_armed;
  logic [MAX_BUS_W-1:0] w_bus;
  logic                 w_rd_sel_ok;
  logic [CH_SEL_W-1:0]  w_rd_idx;
  logic [NUM_CH-1:0]    w_event, w_empty, w_full, w_rd_hit;
  logic [NUM_CH-1:0]    w_do_rd, w_do_wr, w_ovf_set, w_unf_set;
  logic [DATA_W-1:0]    w_head [NUM_CH];
  logic [DATA_W-1:0]    w_rd_mux;
  logic [DATA_W-1:0]    r_rd_data;
  logic                 r_rd_valid;
  logic [NUM_CH-1:0]    r_ovf, r_unf, r_ovf_pend, r_unf_pend;

  // Arming: suppress events until the sync chain and prev register have settled
  always_ff @(posedge iClk) begin
    if (iRst)                  r_arm_cnt <= ARM_W'(SYNC_STAGES + 1);
    else if (r_arm_cnt != '0)  r_arm_cnt <= r_arm_cnt - 1'b1;
  end
  assign w_armed = (r_arm_cnt == '0);

  assign w_bus       = MAX_BUS_W'(iData);
  assign w_rd_sel_ok = iRdEn && (iRdCh != CH_SEL_W'(NO_CHANNEL)) && (iRdCh <= CH_SEL_W'(NUM_CH));
  assign w_rd_idx    = iRdCh - 1'b1;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DATA_W-1:0] r_mem [2**LOG2DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [DATA_W-1:0] w_cap;

    fir_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .iClk    (iClk),
      .iRst    (iRst),
      .iToggle (iDataChanged[n]),
      .iArmed  (w_armed),
      .oEvent  (w_event[n])
    );

    assign w_cap        = DATA_W'(ch_slice(w_bus, n, DATA_W));
    assign w_empty[n]   = (r_wp == r_rp);
    assign w_full[n]    = (r_wp[PW-1] != r_rp[PW-1]) &&
                          (r_wp[LOG2DEPTH-1:0] == r_rp[LOG2DEPTH-1:0]);
    assign w_rd_hit[n]  = w_rd_sel_ok && (w_rd_idx == CH_SEL_W'(n));
    assign w_do_rd[n]   = w_rd_hit[n] && !w_empty[n];
    assign w_unf_set[n] = w_rd_hit[n] && w_empty[n];
    // A same-edge read frees the slot a full FIFO needs; an empty FIFO never bypasses
    assign w_do_wr[n]   = w_event[n] && (!w_full[n] || w_do_rd[n]);
    assign w_ovf_set[n] = w_event[n] && w_full[n] && !w_do_rd[n];
    assign w_head[n]    = r_mem[r_rp[LOG2DEPTH-1:0]];

    always_ff @(posedge iClk) begin
      if (iRst) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_do_wr[n]) r_wp <= r_wp + 1'b1;
        if (w_do_rd[n]) r_rp <= r_rp + 1'b1;
      end
    end

    always_ff @(posedge iClk) begin
      if (w_do_wr[n]) r_mem[r_wp[LOG2DEPTH-1:0]] <= w_cap;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_do_rd[n]) w_rd_mux = w_head[n];
    end
  end

  // Read output stage
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= |w_do_rd;
      if (|w_do_rd) r_rd_data <= w_rd_mux;
    end
  end

  // Sticky status: a clear wins this edge, but a coincident set re-arms one edge later
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_ovf      <= '0;
      r_unf      <= '0;
      r_ovf_pend <= '0;
      r_unf_pend <= '0;
    end else if (iClrStatus) begin
      r_ovf      <= '0;
      r_unf      <= '0;
      r_ovf_pend <= w_ovf_set;
      r_unf_pend <= w_unf_set;
    end else begin
      r_ovf      <= r_ovf | w_ovf_set | r_ovf_pend;
      r_unf      <= r_unf | w_unf_set | r_unf_pend;
      r_ovf_pend <= '0;
      r_unf_pend <= '0;
    end
  end

  assign oRdData    = r_rd_data;
  assign oRdValid   = r_rd_valid;
  assign oPending   = ~w_empty;
  assign oOverflow  = r_ovf;
  assign oUnderflow = r_unf;

endmodule

// File: tb/tb_fir_chan_ingest.sv
// Directed bench for fir_chan_ingest with default parameters (5 ch, 18 bit, depth 4).
module tb_fir_chan_ingest;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 18;

  logic                     iClk = 1'b0;
  logic                     iRst;
  logic [NUM_CH-1:0]        iDataChanged;
  logic [NUM_CH*DATA_W-1:0] iData;
  logic [3:0]               iRdCh;
  logic                     iRdEn;
  logic [DATA_W-1:0]        oRdData;
  logic                     oRdValid;
  logic [NUM_CH-1:0]        oPending;
  logic [NUM_CH-1:0]        oOverflow;
  logic [NUM_CH-1:0]        oUnderflow;
  logic                     iClrStatus;

  int checks   = 0;
  int failures = 0;

  fir_chan_ingest dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iDataChanged (iDataChanged),
    .iData        (iData),
    .iRdCh        (iRdCh),
    .iRdEn        (iRdEn),
    .oRdData      (oRdData),
    .oRdValid     (oRdValid),
    .oPending     (oPending),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow),
    .iClrStatus   (iClrStatus)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // New sample on channel ch, then hold for the source stability window
  task automatic send(input int ch, input logic [DATA_W-1:0] val);
    iData[ch*DATA_W +: DATA_W] = val;
    iDataChanged[ch] = ~iDataChanged[ch];
    repeat (4) tick();
  endtask

  task automatic rd(input logic [3:0] sel);
    iRdCh = sel;
    iRdEn = 1'b1;
    tick();
    iRdEn = 1'b0;
    iRdCh = 4'd0;
  endtask

  initial begin
    logic seen;
    int   n;
    iRst = 1'b1; iDataChanged = '0; iData = '0; iRdCh = '0; iRdEn = 1'b0; iClrStatus = 1'b0;
    iDataChanged[0] = 1'b1;
    repeat (3) tick();
    iRst = 1'b0;
    chk("rst_rddata",   oRdData,    0);
    chk("rst_rdvalid",  oRdValid,   0);
    chk("rst_pending",  oPending,   0);
    chk("rst_underflow", oUnderflow, 0);

    // idle-high toggle must not produce a sample during arming
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (oPending != '0) seen = 1'b1;
    end
    chk("arm_no_pending", seen, 0);
    chk("arm_overflow",   oOverflow, 0);

    // single sample on ch1, read with select 2
    iData[1*DATA_W +: DATA_W] = 18'h10000;
    iDataChanged[1] = 1'b1;
    n = 0;
    while (!oPending[1] && n < 4) begin tick(); n++; end
    chk("ch1_pending", oPending[1], 1);
    tick();
    rd(4'd2);
    chk("ch1_valid",   oRdValid, 1);
    chk("ch1_data",    oRdData, 18'h10000);
    chk("ch1_drained", oPending[1], 0);
    tick();
    chk("valid_pulse", oRdValid, 0);

    // overflow on ch0, then drain and underflow
    for (int v = 1; v <= 5; v++) send(0, DATA_W'(v));
    chk("ch0_overflow", oOverflow, 5'b00001);
    for (int v = 1; v <= 4; v++) begin
      rd(4'd1);
      chk("ch0_rd_valid", oRdValid, 1);
      chk("ch0_rd_data",  oRdData, v);
    end
    rd(4'd1);
    chk("ch0_empty_valid", oRdValid, 0);
    chk("ch0_empty_hold",  oRdData, 4);
    chk("ch0_underflow",   oUnderflow, 5'b00001);
    iClrStatus = 1'b1; tick(); iClrStatus = 1'b0;
    chk("clr_overflow",  oOverflow, 0);
    chk("clr_underflow", oUnderflow, 0);

    // ch3 full: read and new capture land on the same edge
    for (int v = 1; v <= 4; v++) send(3, DATA_W'(8'h30 + v));
    iData[3*DATA_W +: DATA_W] = 18'h35;
    iDataChanged[3] = ~iDataChanged[3];
    tick(); tick();
    rd(4'd4);
    chk("ch3_coinc_valid", oRdValid, 1);
    chk("ch3_coinc_data",  oRdData, 18'h31);
    chk("ch3_no_overflow", oOverflow, 0);
    tick();
    for (int v = 2; v <= 5; v++) begin
      rd(4'd4);
      chk("ch3_rd_data", oRdData, 8'h30 + v);
    end
    chk("ch3_drained", oPending[3], 0);

    // simultaneous events on every channel
    for (int c = 0; c < NUM_CH; c++) iData[c*DATA_W +: DATA_W] = DATA_W'(10 + c);
    iDataChanged = ~iDataChanged;
    repeat (4) tick();
    chk("all_pending", oPending, 5'b11111);
    for (int c = 0; c < NUM_CH; c++) begin
      rd(4'(c + 1));
      chk("all_rd_data", oRdData, 10 + c);
    end
    chk("all_no_status", {oOverflow, oUnderflow}, 0);

    // out-of-range select is ignored
    rd(4'd7);
    chk("bad_sel_valid",  oRdValid, 0);
    chk("bad_sel_status", oUnderflow, 0);

    // clear coinciding with an underflow: clear now, flag returns one edge later
    iClrStatus = 1'b1;
    rd(4'd5);
    iClrStatus = 1'b0;
    chk("clr_wins", oUnderflow, 0);
    tick();
    chk("clr_rearm", oUnderflow, 5'b10000);
    iClrStatus = 1'b1; tick(); iClrStatus = 1'b0;

    // reset discards buffered samples on ch2
    send(2, 18'h21);
    send(2, 18'h22);
    chk("ch2_pending", oPending[2], 1);
    iRst = 1'b1; tick(); iRst = 1'b0;
    chk("rst2_pending", oPending, 0);
    chk("rst2_rddata",  oRdData, 0);
    rd(4'd3);
    chk("rst2_rd_valid",  oRdValid, 0);
    chk("rst2_underflow", oUnderflow, 5'b00100);
    iClrStatus = 1'b1; tick(); iClrStatus = 1'b0;
    chk("rst2_clr", oUnderflow, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oPending != '0) seen = 1'b1;
    end
    chk("rst2_no_spurious", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
